// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle controller: FSM states, opcode map and ALU control codes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;
  localparam logic [2:0] OP_BNE   = 3'b110;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'd0,
    AOP_SUB   = 2'd1,
    AOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

endpackage

// File: rtl/mc_aludec.sv
// ALU control decode: fixed ADD/SUB for address and compare work, raw funct for R-type.
module mc_aludec
  import multicycle_ctrl_pkg::*;
#(
  parameter int FW  = 4,
  parameter int ACW = 4
) (
  input  aluop_t         aluop_i,
  input  logic [FW-1:0]  funct_i,
  output logic [ACW-1:0] alucontrol_o
);

  // R-type passes funct straight through, so FW and ACW must match.
  always_comb begin
    case (aluop_i)
      AOP_SUB:   alucontrol_o = ACW'(ALU_SUB);
      AOP_FUNCT: alucontrol_o = ACW'(funct_i);
      default:   alucontrol_o = ACW'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-16 controller: Moore FSM with memory handshake, BNE, illegal-op trap and retire counter.
module multicycle_controller
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW  = 3,
  parameter int FW   = 4,
  parameter int ACW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  op,
  input  logic [FW-1:0]   funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            iord,
  output logic            memwrite,
  output logic            irwrite,
  output logic            pcen,
  output logic [1:0]      pcsrc,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [ACW-1:0]  alucontrol,
  output logic            regdst,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            instr_done,
  output logic            illegal_op,
  output logic [CNTW-1:0] retired
);

  state_t            state_q, state_d;
  logic              bne_q;
  logic [CNTW-1:0]   retired_q;
  aluop_t            aluop;

  mc_aludec #(.FW(FW), .ACW(ACW)) u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

  assign retired = retired_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = AOP_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OPW'(OP_RTYPE): state_d = S_EXEC;
          OPW'(OP_LW),
          OPW'(OP_SW):    state_d = S_MEMADR;
          OPW'(OP_BEQ),
          OPW'(OP_BNE):   state_d = S_BRANCH;
          OPW'(OP_ADDI):  state_d = S_ADDIEX;
          OPW'(OP_J):     state_d = S_JUMP;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = AOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = AOP_SUB;
        pcsrc      = 2'b01;
        pcen       = bne_q ? ~zero : zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
        state_d    = S_TRAP;
      end
      // Corrupted state encodings park in TRAP rather than running off.
      default: state_d = S_TRAP;
    endcase
  end

  // Branch sense is latched in DECODE so BRANCH does not depend on op staying valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bne_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) bne_q <= (op == OPW'(OP_BNE));
      if (instr_done) retired_q <= retired_q + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction table with done-cycle scoreboard plus wait/trap/reset sequences.
module tb_multicycle_controller;
  import multicycle_ctrl_pkg::*;

  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      op = '0;
  logic [3:0]      funct = '0;
  logic            zero = 1'b0;
  logic            mem_ready = 1'b0;
  logic            mem_req, iord, memwrite, irwrite, pcen;
  logic [1:0]      pcsrc, alusrcb;
  logic            alusrca, regdst, memtoreg, regwrite, instr_done, illegal_op;
  logic [3:0]      alucontrol;
  logic [CNTW-1:0] retired;

  multicycle_controller #(.OPW(3), .FW(4), .ACW(4), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .instr_done(instr_done),
    .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [CNTW-1:0] exp_ret;

  // done vector: {pcen, pcsrc, regwrite, regdst, memtoreg, memwrite, mem_req, iord, alusrca, alucontrol}
  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [3:0]  funct;
    logic        zero;
    int          cyc;
    logic [13:0] dv;
  } vec_t;

  vec_t tbl[10];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] o, input logic [3:0] f,
                              input logic z, input int cyc, input logic [13:0] dv);
    vec_t v;
    v.name = name; v.op = o; v.funct = f; v.zero = z; v.cyc = cyc; v.dv = dv;
    return v;
  endfunction

  function automatic logic [13:0] done_vec();
    return {pcen, pcsrc, regwrite, regdst, memtoreg, memwrite, mem_req, iord, alusrca, alucontrol};
  endfunction

  function automatic logic [22:0] all_outs();
    return {mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb, alucontrol,
            regdst, memtoreg, regwrite, instr_done, illegal_op, retired};
  endfunction

  // Leaves the DUT in FETCH, 2 time units after the clock edge.
  task automatic do_reset();
    reset = 1'b0; mem_ready = 1'b1; op = 3'b000; zero = 1'b0;
    @(posedge clk); #2;
    chk("reset_outs", 32'(all_outs()), 32'd0);
    reset = 1'b1;
    #1;
    chk("idle_outs", 32'(all_outs()), 32'd0);
    @(posedge clk); #2;
    exp_ret = '0;
  endtask

  task automatic run_instr(input vec_t v);
    vec_t e;
    int n;
    op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
    sb.push_back(v);
    #1;
    n = 1;
    chk({v.name, "_fetch"}, 32'({mem_req, irwrite, pcen, iord, alusrca, alusrcb, memwrite, regwrite}),
        32'(9'b111000100));
    while (!instr_done && n < 20) begin
      @(posedge clk); #2;
      n++;
      if (v.op == OP_RTYPE && n == 3)
        chk({v.name, "_exec"}, 32'({alusrca, alusrcb, alucontrol}), 32'({1'b1, 2'b00, v.funct}));
    end
    e = sb.pop_front();
    chk({e.name, "_cycles"}, 32'(n), 32'(e.cyc));
    chk({e.name, "_done"}, 32'(done_vec()), 32'(e.dv));
    @(posedge clk); #2;
    exp_ret = exp_ret + 1'b1;
    chk({e.name, "_retired"}, 32'(retired), 32'(exp_ret));
    chk({e.name, "_refetch"}, 32'({mem_req, iord, memwrite}), 32'(3'b100));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int irw, mrq, done_at;

    //                   name     op        funct  z cyc  pcen pcsrc rw rd mtr mw mrq iord sa alu
    tbl[0] = mk("rtype6", OP_RTYPE, 4'h6, 1'b0, 4, {1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl[1] = mk("lw",     OP_LW,    4'h0, 1'b0, 5, {1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl[2] = mk("sw",     OP_SW,    4'h0, 1'b0, 4, {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0});
    tbl[3] = mk("beq_z1", OP_BEQ,   4'h0, 1'b1, 3, {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1});
    tbl[4] = mk("beq_z0", OP_BEQ,   4'h0, 1'b0, 3, {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1});
    tbl[5] = mk("bne_z1", OP_BNE,   4'h0, 1'b1, 3, {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1});
    tbl[6] = mk("bne_z0", OP_BNE,   4'h0, 1'b0, 3, {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1});
    tbl[7] = mk("addi",   OP_ADDI,  4'h0, 1'b0, 4, {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl[8] = mk("jump",   OP_J,     4'h0, 1'b0, 3, {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl[9] = mk("rtype3", OP_RTYPE, 4'h3, 1'b1, 4, {1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});

    do_reset();
    for (int i = 0; i < 10; i++) run_instr(tbl[i]);

    // LW with two wait cycles in FETCH and one in MEMRD; ready=1 in DECODE/MEMADR must be ignored.
    pat = 8'b11011100;
    op = OP_LW; irw = 0; mrq = 0; done_at = 0;
    for (int i = 0; i < 12; i++) begin
      mem_ready = (i < 8) ? pat[i] : 1'b1;
      #1;
      if (irwrite) irw++;
      if (mem_req) mrq++;
      if (instr_done) begin
        done_at = i + 1;
        chk("lwwait_wb", 32'({regwrite, memtoreg, regdst}), 32'(3'b110));
        break;
      end
      @(posedge clk); #2;
    end
    chk("lwwait_cycles", 32'(done_at), 32'd8);
    chk("lwwait_irwrite", 32'(irw), 32'd1);
    chk("lwwait_memreq", 32'(mrq), 32'd5);
    @(posedge clk); #2;
    exp_ret = exp_ret + 1'b1;
    chk("lwwait_retired", 32'(retired), 32'(exp_ret));

    // Illegal opcode: parks in TRAP, nothing escapes it, reset clears it asynchronously.
    op = 3'b111; mem_ready = 1'b1;
    @(posedge clk); #2;
    chk("trap_decode", 32'(illegal_op), 32'd0);
    @(posedge clk); #2;
    for (int i = 0; i < 5; i++) begin
      op = OP_LW;
      mem_ready = i[0];
      #1;
      chk("trap_hold", 32'({illegal_op, mem_req, irwrite, pcen, regwrite, memwrite, instr_done}),
          32'(7'b1000000));
      chk("trap_retired", 32'(retired), 32'(exp_ret));
      @(posedge clk); #2;
    end
    #1;
    reset = 1'b0;
    #1;
    chk("trap_async_clear", 32'({illegal_op, mem_req}), 32'd0);
    do_reset();

    // 16 ADDIs: the 4-bit retire counter wraps 15 -> 0.
    for (int i = 0; i < 16; i++) run_instr(mk("addi_wrap", OP_ADDI, 4'h0, 1'b0, 4,
      {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}));
    chk("wrap_zero", 32'(retired), 32'd0);

    // Stall a store in MEMWR, then pull reset between clock edges.
    op = OP_SW; mem_ready = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    mem_ready = 1'b0;
    @(posedge clk); #2;
    #1;
    chk("memwr_stall", 32'({mem_req, memwrite, iord, instr_done}), 32'(4'b1110));
    reset = 1'b0;
    #1;
    chk("memwr_async_drop", 32'({mem_req, memwrite}), 32'd0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
